// File: rtl/ahb_bus_pkg.sv
// Shared AHB encodings for the N-master / M-slave interconnect.
// Used by ahb_arbiter and ahb_bus_nxm.
package ahb_bus_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahb_arbiter.sv
// AHB arbiter: one-hot grant plus address-bus ownership (HMASTER/HMASTLOCK).
// Fixed priority by default; round-robin when AHB_RR_ARB_EN is defined.
module ahb_arbiter
  import ahb_bus_pkg::*;
#(
  parameter int N_MST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_MST-1:0] hbusreq,
  input  logic [N_MST-1:0] hlock,
  input  logic             hready,
  input  logic [1:0]       htrans,
  output logic [N_MST-1:0] grant,
  output logic [2:0]       hmaster,
  output logic             hmastlock
);

  logic [N_MST-1:0] grant_q, grant_d, next_grant;
  logic [2:0]       grant_idx, next_idx;
  logic [2:0]       hmaster_q, hmaster_d;
  logic             hmastlock_q, hmastlock_d;
  logic             owner_locked, update, found;
`ifdef AHB_RR_ARB_EN
  logic [2:0]       last_q, last_d;
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_MST; i++)
      if (grant_q[i]) grant_idx = 3'(i);
  end

  // Idle bus parks on master 0 because next_idx keeps its zero default.
  always_comb begin
    found      = 1'b0;
    next_idx   = '0;
    next_grant = '0;
`ifdef AHB_RR_ARB_EN
    for (int i = 0; i < N_MST; i++)
      if (!found && hbusreq[i] && (3'(i) > last_q)) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
    for (int i = 0; i < N_MST; i++)
      if (!found && hbusreq[i]) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
`else
    for (int i = 0; i < N_MST; i++)
      if (!found && hbusreq[i]) begin
        found    = 1'b1;
        next_idx = 3'(i);
      end
`endif
    for (int i = 0; i < N_MST; i++)
      next_grant[i] = (next_idx == 3'(i));
  end

  assign owner_locked = |(hlock & grant_q);
  assign update       = hready && !owner_locked && (htrans != HTRANS_BUSY);

  always_comb begin
    grant_d     = update ? next_grant : grant_q;
    hmaster_d   = hready ? grant_idx : hmaster_q;
    hmastlock_d = hready ? owner_locked : hmastlock_q;
`ifdef AHB_RR_ARB_EN
    last_d      = (update && (next_grant != grant_q)) ? next_idx : last_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q     <= N_MST'(1);
      hmaster_q   <= '0;
      hmastlock_q <= 1'b0;
`ifdef AHB_RR_ARB_EN
      last_q      <= '0;
`endif
    end else begin
      grant_q     <= grant_d;
      hmaster_q   <= hmaster_d;
      hmastlock_q <= hmastlock_d;
`ifdef AHB_RR_ARB_EN
      last_q      <= last_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign hmaster   = hmaster_q;
  assign hmastlock = hmastlock_q;

endmodule

// File: rtl/ahb_bus_nxm.sv
// Parametrised AHB interconnect: arbiter, decoder, ERROR default slave and muxes.
// Define AHB_RR_ARB_EN for round-robin arbitration instead of fixed priority.
module ahb_bus_nxm
  import ahb_bus_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int N_SLV  = 5,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [N_SLV-1:0][ADDR_W-1:0] SLV_MASK = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MST-1:0]             HBUSREQ_M,
  input  logic [N_MST-1:0]             HLOCK_M,
  input  logic [N_MST-1:0]             HWRITE_M,
  input  logic [N_MST-1:0][ADDR_W-1:0] HADDR_M,
  input  logic [N_MST-1:0][1:0]        HTRANS_M,
  input  logic [N_MST-1:0][2:0]        HSIZE_M,
  input  logic [N_MST-1:0][DATA_W-1:0] HWDATA_M,
  output logic [N_MST-1:0]             HGRANT_M,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic [1:0]                   HRESP,
  output logic [ADDR_W-1:0]            HADDR,
  output logic [1:0]                   HTRANS,
  output logic [2:0]                   HSIZE,
  output logic                         HWRITE,
  output logic [DATA_W-1:0]            HWDATA,
  output logic [2:0]                   HMASTER,
  output logic                         HMASTLOCK,
  output logic [N_SLV-1:0]             HSEL_S,
  input  logic [N_SLV-1:0][DATA_W-1:0] HRDATA_S,
  input  logic [N_SLV-1:0]             HREADY_S,
  input  logic [N_SLV-1:0][1:0]        HRESP_S
);

  // Index N_SLV stands for the default slave in sel_idx / dsel_q.
  localparam logic [4:0] DEF_SLV = 5'(N_SLV);

  logic [2:0]        hmaster, dmst_q, dmst_d;
  logic [4:0]        sel_idx, dsel_q, dsel_d;
  logic              hready, dec_hit, unmapped_xfer, ds_ready;
  logic [1:0]        hresp, ds_resp;
  logic [DATA_W-1:0] hrdata;
  ds_state_e         ds_q, ds_d;

  ahb_arbiter #(.N_MST(N_MST)) u_arbiter (
    .clk       (clk),
    .rst       (rst),
    .hbusreq   (HBUSREQ_M),
    .hlock     (HLOCK_M),
    .hready    (hready),
    .htrans    (HTRANS),
    .grant     (HGRANT_M),
    .hmaster   (hmaster),
    .hmastlock (HMASTLOCK)
  );

  assign HMASTER = hmaster;

  always_comb begin
    HADDR  = '0;
    HTRANS = HTRANS_IDLE;
    HSIZE  = '0;
    HWRITE = 1'b0;
    for (int i = 0; i < N_MST; i++)
      if (hmaster == 3'(i)) begin
        HADDR  = HADDR_M[i];
        HTRANS = HTRANS_M[i];
        HSIZE  = HSIZE_M[i];
        HWRITE = HWRITE_M[i];
      end
  end

  // Scanning downwards lets the lowest matching slave overwrite the others.
  always_comb begin
    sel_idx = DEF_SLV;
    for (int s = N_SLV - 1; s >= 0; s--)
      if ((HADDR & SLV_MASK[s]) == SLV_BASE[s]) sel_idx = 5'(s);
  end

  always_comb begin
    HSEL_S = '0;
    for (int s = 0; s < N_SLV; s++)
      HSEL_S[s] = (sel_idx == 5'(s));
  end

  assign dec_hit       = (sel_idx != DEF_SLV);
  assign unmapped_xfer = !dec_hit && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));

  assign ds_ready = (ds_q != DS_ERR1);
  assign ds_resp  = (ds_q == DS_OKAY) ? HRESP_OKAY : HRESP_ERROR;

  always_comb begin
    ds_d = ds_q;
    case (ds_q)
      DS_OKAY: if (unmapped_xfer && hready) ds_d = DS_ERR1;
      DS_ERR1: ds_d = DS_ERR2;
      DS_ERR2: ds_d = (unmapped_xfer && hready) ? DS_ERR1 : DS_OKAY;
      default: ds_d = DS_OKAY;
    endcase
  end

  always_comb begin
    dmst_d = hready ? hmaster : dmst_q;
    dsel_d = hready ? sel_idx : dsel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmst_q <= '0;
      dsel_q <= DEF_SLV;
      ds_q   <= DS_OKAY;
    end else begin
      dmst_q <= dmst_d;
      dsel_q <= dsel_d;
      ds_q   <= ds_d;
    end
  end

  always_comb begin
    hrdata = '0;
    hready = ds_ready;
    hresp  = ds_resp;
    for (int s = 0; s < N_SLV; s++)
      if (dsel_q == 5'(s)) begin
        hrdata = HRDATA_S[s];
        hready = HREADY_S[s];
        hresp  = HRESP_S[s];
      end
  end

  always_comb begin
    HWDATA = '0;
    for (int i = 0; i < N_MST; i++)
      if (dmst_q == 3'(i)) HWDATA = HWDATA_M[i];
  end

  assign HRDATA = hrdata;
  assign HREADY = hready;
  assign HRESP  = hresp;

endmodule

// File: tb/tb_ahb_bus_nxm.sv
// Self-checking bench for ahb_bus_nxm: directed scenarios followed by random traffic,
// compared every cycle against a transaction-level model of the bus (honours AHB_RR_ARB_EN).
module tb_ahb_bus_nxm;
  import ahb_bus_pkg::*;

  localparam int N_MST  = 2;
  localparam int N_SLV  = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam logic [N_SLV-1:0][ADDR_W-1:0] SLV_BASE =
    {32'h2000_0000, 32'h0000_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000};
  localparam logic [N_SLV-1:0][ADDR_W-1:0] SLV_MASK =
    {32'hF000_0000, 32'hF000_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};

  logic clk, rst;
  logic [N_MST-1:0]             hbusreq_m, hlock_m, hwrite_m, hgrant_m;
  logic [N_MST-1:0][ADDR_W-1:0] haddr_m;
  logic [N_MST-1:0][1:0]        htrans_m;
  logic [N_MST-1:0][2:0]        hsize_m;
  logic [N_MST-1:0][DATA_W-1:0] hwdata_m;
  logic [DATA_W-1:0]            hrdata, hwdata;
  logic [ADDR_W-1:0]            haddr;
  logic                         hready, hwrite, hmastlock;
  logic [1:0]                   hresp, htrans;
  logic [2:0]                   hsize, hmaster;
  logic [N_SLV-1:0]             hsel_s, hready_s;
  logic [N_SLV-1:0][DATA_W-1:0] hrdata_s;
  logic [N_SLV-1:0][1:0]        hresp_s;

  int checks, errors;
  int m_grant, m_hmaster, m_hmastlock, m_dmst, m_dsel, m_ds, m_last;

  ahb_bus_nxm #(
    .N_MST(N_MST), .N_SLV(N_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .SLV_BASE(SLV_BASE), .SLV_MASK(SLV_MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .HBUSREQ_M(hbusreq_m), .HLOCK_M(hlock_m), .HWRITE_M(hwrite_m),
    .HADDR_M(haddr_m), .HTRANS_M(htrans_m), .HSIZE_M(hsize_m), .HWDATA_M(hwdata_m),
    .HGRANT_M(hgrant_m), .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp),
    .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite), .HWDATA(hwdata),
    .HMASTER(hmaster), .HMASTLOCK(hmastlock), .HSEL_S(hsel_s),
    .HRDATA_S(hrdata_s), .HREADY_S(hready_s), .HRESP_S(hresp_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int decodeAddr(input logic [ADDR_W-1:0] a);
    for (int s = 0; s < N_SLV; s++)
      if ((a & SLV_MASK[s]) == SLV_BASE[s]) return s;
    return N_SLV;
  endfunction

  // Next owner among the current requesters; nobody requesting parks on master 0.
  function automatic int arbitrate();
`ifdef AHB_RR_ARB_EN
    for (int k = 0; k < N_MST; k++)
      if (hbusreq_m[(m_last + 1 + k) % N_MST]) return (m_last + 1 + k) % N_MST;
`else
    for (int k = 0; k < N_MST; k++)
      if (hbusreq_m[k]) return k;
`endif
    return 0;
  endfunction

  function automatic logic [ADDR_W-1:0] randomAddr();
    logic [ADDR_W-1:0] off;
    off = 32'($urandom_range(0, 255)) << 2;
    case ($urandom_range(0, 6))
      0: return off;
      1: return 32'h0001_0000 | off;
      2: return 32'h0002_0000 | off;
      3: return 32'h0500_0000 | off;
      4: return 32'h2000_1000 | off;
      5: return 32'hF000_0000 | off;
      default: return 32'h3000_0000 | off;
    endcase
  endfunction

  task automatic modelReset();
    m_grant = 0; m_hmaster = 0; m_hmastlock = 0;
    m_dmst = 0; m_dsel = N_SLV; m_ds = 0; m_last = 0;
  endtask

  task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    for (int m = 0; m < N_MST; m++) begin
      hbusreq_m[m] = 1'($urandom_range(0, 1));
      hlock_m[m]   = ($urandom_range(0, 7) == 0);
      hwrite_m[m]  = 1'($urandom_range(0, 1));
      htrans_m[m]  = 2'($urandom_range(0, 3));
      hsize_m[m]   = 3'($urandom_range(0, 2));
      haddr_m[m]   = randomAddr();
      hwdata_m[m]  = $urandom();
    end
    for (int s = 0; s < N_SLV; s++) begin
      hrdata_s[s] = $urandom();
      hready_s[s] = ($urandom_range(0, 3) != 0);
      hresp_s[s]  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : HRESP_OKAY;
    end
  endtask

  // Compare the current cycle against the model, then advance the model across one edge.
  task automatic checkOutput(input string tag);
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_rdata;
    logic [1:0]        e_trans, e_resp;
    logic [N_SLV-1:0]  e_hsel;
    logic              e_rdy, unmapped;
    int e_sel, n_grant, n_last, n_hm, n_lock, n_dmst, n_dsel, n_ds;
    @(negedge clk);
    e_addr  = haddr_m[m_hmaster];
    e_trans = htrans_m[m_hmaster];
    e_sel   = decodeAddr(e_addr);
    e_hsel  = '0;
    if (e_sel < N_SLV) e_hsel[e_sel] = 1'b1;
    if (m_dsel == N_SLV) begin
      e_rdy   = (m_ds != 1);
      e_resp  = (m_ds == 0) ? HRESP_OKAY : HRESP_ERROR;
      e_rdata = '0;
    end else begin
      e_rdy   = hready_s[m_dsel];
      e_resp  = hresp_s[m_dsel];
      e_rdata = hrdata_s[m_dsel];
    end
    checkValue({tag, ".hgrant"},    64'(hgrant_m),  64'(1 << m_grant));
    checkValue({tag, ".hmaster"},   64'(hmaster),   64'(m_hmaster));
    checkValue({tag, ".hmastlock"}, 64'(hmastlock), 64'(m_hmastlock));
    checkValue({tag, ".haddr"},     64'(haddr),     64'(e_addr));
    checkValue({tag, ".htrans"},    64'(htrans),    64'(e_trans));
    checkValue({tag, ".hsize"},     64'(hsize),     64'(hsize_m[m_hmaster]));
    checkValue({tag, ".hwrite"},    64'(hwrite),    64'(hwrite_m[m_hmaster]));
    checkValue({tag, ".hsel"},      64'(hsel_s),    64'(e_hsel));
    checkValue({tag, ".hwdata"},    64'(hwdata),    64'(hwdata_m[m_dmst]));
    checkValue({tag, ".hready"},    64'(hready),    64'(e_rdy));
    checkValue({tag, ".hresp"},     64'(hresp),     64'(e_resp));
    checkValue({tag, ".hrdata"},    64'(hrdata),    64'(e_rdata));
    n_grant = m_grant; n_last = m_last;
    if (e_rdy && !hlock_m[m_grant] && (e_trans != HTRANS_BUSY)) begin
      n_grant = arbitrate();
      if (n_grant != m_grant) n_last = n_grant;
    end
    n_hm = m_hmaster; n_lock = m_hmastlock; n_dmst = m_dmst; n_dsel = m_dsel;
    if (e_rdy) begin
      n_hm = m_grant; n_lock = int'(hlock_m[m_grant]); n_dmst = m_hmaster; n_dsel = e_sel;
    end
    unmapped = (e_sel == N_SLV) && ((e_trans == HTRANS_NONSEQ) || (e_trans == HTRANS_SEQ));
    n_ds = (m_ds == 1) ? 2 : ((e_rdy && unmapped) ? 1 : 0);
    @(posedge clk);
    m_grant = n_grant; m_last = n_last; m_hmaster = n_hm; m_hmastlock = n_lock;
    m_dmst = n_dmst; m_dsel = n_dsel; m_ds = n_ds;
    #1;
  endtask

  initial begin
    logic [1:0] exp_grant;
    checks = 0; errors = 0;
    rst = 1'b1;
    hbusreq_m = '0; hlock_m = '0; hwrite_m = '0; haddr_m = '0; htrans_m = '0;
    hsize_m = '0; hwdata_m = '0; hrdata_s = '0; hready_s = '1; hresp_s = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    $display("[TB] reset to default ownership");
    checkValue("reset.hgrant", 64'(hgrant_m), 64'(2'b01));
    checkValue("reset.hmaster", 64'(hmaster), 64'(0));
    checkValue("reset.hready", 64'(hready), 64'(1));
    checkValue("reset.hresp", 64'(hresp), 64'(HRESP_OKAY));
    checkValue("reset.hrdata", 64'(hrdata), 64'(0));
    checkOutput("idle");

    $display("[TB] single requester");
    hbusreq_m = 2'b10; htrans_m[1] = HTRANS_NONSEQ; haddr_m[1] = 32'h0001_0000; hwrite_m = '0;
    checkOutput("single.req");
    checkValue("single.grant_t1", 64'(hgrant_m), 64'(2'b10));
    checkValue("single.hmaster_t1", 64'(hmaster), 64'(0));
    checkOutput("single.own");
    #1;
    checkValue("single.hsel", 64'(hsel_s), 64'(5'b00010));
    hrdata_s[1] = 32'hDEAD_BEEF;
    checkOutput("single.addr");
    htrans_m[1] = HTRANS_IDLE;
    #1;
    checkValue("single.hrdata", 64'(hrdata), 64'(32'hDEAD_BEEF));
    checkValue("single.hready", 64'(hready), 64'(1));
    checkOutput("single.data");

    $display("[TB] unmapped address");
    haddr_m[1] = 32'hF000_0000; htrans_m[1] = HTRANS_NONSEQ; hwrite_m[1] = 1'b1;
    #1;
    checkValue("unmap.hsel", 64'(hsel_s), 64'(0));
    checkOutput("unmap.addr");
    htrans_m[1] = HTRANS_IDLE;
    #1;
    checkValue("unmap.err1.hready", 64'(hready), 64'(0));
    checkValue("unmap.err1.hresp", 64'(hresp), 64'(HRESP_ERROR));
    checkOutput("unmap.err1");
    checkValue("unmap.err2.hready", 64'(hready), 64'(1));
    checkValue("unmap.err2.hresp", 64'(hresp), 64'(HRESP_ERROR));
    checkOutput("unmap.err2");
    checkValue("unmap.okay.hresp", 64'(hresp), 64'(HRESP_OKAY));

    $display("[TB] locked burst");
    hbusreq_m = 2'b01; hlock_m = 2'b01; hwrite_m = '0;
    checkOutput("lock.req");
    checkOutput("lock.own");
    checkValue("lock.hmaster", 64'(hmaster), 64'(0));
    checkValue("lock.hmastlock", 64'(hmastlock), 64'(1));
    hbusreq_m = 2'b10;
    for (int b = 0; b < 4; b++) begin
      htrans_m[0] = (b == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
      haddr_m[0]  = 32'h0002_0000 + 32'(4 * b);
      checkOutput("lock.beat");
      checkValue("lock.beat.hgrant", 64'(hgrant_m), 64'(2'b01));
    end
    htrans_m[0] = HTRANS_IDLE; hlock_m = '0;
    checkOutput("lock.release");
    checkValue("lock.release.hgrant", 64'(hgrant_m), 64'(2'b10));

    $display("[TB] wait state during request");
    htrans_m[1] = HTRANS_NONSEQ; haddr_m[1] = 32'h0002_0040;
    checkOutput("wait.own");
    checkOutput("wait.addr");
    hready_s[2] = 1'b0; hbusreq_m = 2'b01; htrans_m[1] = HTRANS_IDLE;
    for (int w = 0; w < 3; w++) begin
      #1;
      checkValue("wait.hready", 64'(hready), 64'(0));
      checkValue("wait.hmaster", 64'(hmaster), 64'(1));
      checkValue("wait.hgrant", 64'(hgrant_m), 64'(2'b10));
      checkOutput("wait.stall");
    end
    hready_s[2] = 1'b1;
    #1;
    checkValue("wait.resume.hready", 64'(hready), 64'(1));
    checkOutput("wait.resume");
    checkValue("wait.handover.hgrant", 64'(hgrant_m), 64'(2'b01));

    $display("[TB] both masters requesting");
    hbusreq_m = 2'b11;
    for (int k = 0; k < 4; k++) begin
      checkOutput("both");
`ifdef AHB_RR_ARB_EN
      exp_grant = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
      exp_grant = 2'b01;
`endif
      checkValue("both.hgrant", 64'(hgrant_m), 64'(exp_grant));
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
        #1;
        checkValue("midreset.hready", 64'(hready), 64'(1));
        checkValue("midreset.hresp", 64'(hresp), 64'(HRESP_OKAY));
        checkValue("midreset.hgrant", 64'(hgrant_m), 64'(2'b01));
      end
      applyStimulus();
      checkOutput("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_bus_nxm.md
# ahb_bus_nxm

Parametrised AHB interconnect combining an N-master arbiter, an address decoder for M slaves, a default slave, and address/data-phase multiplexers. It replaces the fixed 2-master/2-slave bus between the CPU master ports and the memory and peripheral wrappers (IM, DM, ROM, sensor, DRAM). It adds lock handling, configurable arbitration, and an ERROR-responding default slave.

## Interface
- N_MST, 2, number of masters (1..8)
- N_SLV, 5, number of slaves (1..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SLV_BASE, {N_SLV{ADDR_W'0}}, per-slave base address
- SLV_MASK, {N_SLV{ADDR_W'0}}, per-slave mask; slave s hits when (HADDR & SLV_MASK[s]) == SLV_BASE[s]

Ports:
- clk  in  1  bus clock; single clock domain
- rst  in  1  synchronous, active-high reset
- HBUSREQ_M, HLOCK_M, HWRITE_M  in  [N_MST]  per-master request, lock and write signals
- HADDR_M  in  [N_MST][ADDR_W]  per-master address
- HTRANS_M  in  [N_MST][2]  per-master transfer type
- HSIZE_M  in  [N_MST][3]  per-master transfer size
- HWDATA_M  in  [N_MST][DATA_W]  per-master write data
- HGRANT_M  out  [N_MST]  one-hot grant
- HRDATA  out  DATA_W  read data to all masters
- HREADY  out  1  transfer-done to masters and slaves
- HRESP  out  2  response to masters
- HADDR, HTRANS, HSIZE, HWRITE, HWDATA  out  per-field widths  muxed outputs to slaves
- HMASTER  out  3  index of the address-bus owner
- HMASTLOCK  out  1  locked sequence in progress
- HSEL_S  out  [N_SLV]  one-hot slave select
- HRDATA_S  in  [N_SLV][DATA_W]  per-slave read data
- HREADY_S  in  [N_SLV]  per-slave ready
- HRESP_S  in  [N_SLV][2]  per-slave response

## Operation
- **Arbiter:**
  - grant_q is one-hot and drives HGRANT_M directly.
  - The next owner is evaluated every cycle. grant_q updates only when HREADY=1, the granted master's HLOCK_M=0, and the current address-phase HTRANS is not BUSY.
  - If no master requests, grant goes to master 0, the default master.
- **Ownership:** HMASTER and HMASTLOCK load from grant_q index and HLOCK_M[granted] on a clock edge with HREADY=1.
- **Address mux:** HADDR, HTRANS, HSIZE and HWRITE are selected by HMASTER, combinationally.
- **Decoder:** HSEL_S is computed combinationally from HADDR.
  - If several slaves match, the lowest index wins.
  - If none match, the default slave is selected and HSEL_S=0.
- **Data-phase registers:** on HREADY=1 edges, dmst_q←HMASTER and dsel_q←decoded slave (or default).
- **Data-phase muxing:**
  - HWDATA is selected by dmst_q.
  - HRDATA, HREADY and HRESP are selected by dsel_q.
- **Default slave FSM** (DS_OKAY, DS_ERR1, DS_ERR2):
  - DS_OKAY: drives HREADY=1, HRESP=OKAY, HRDATA=0.
  - DS_OKAY→DS_ERR1 when the default slave is selected, HTRANS is NONSEQ or SEQ, and HREADY=1.
  - DS_ERR1: drives HREADY=0, HRESP=ERROR. Always advances to DS_ERR2.
  - DS_ERR2: drives HREADY=1, HRESP=ERROR. Returns to DS_OKAY, or to DS_ERR1 if another unmapped NONSEQ/SEQ is sampled.
  - IDLE and BUSY transfers to unmapped addresses complete with zero-wait OKAY.
- RETRY and SPLIT from slaves are forwarded unchanged; the arbiter does not act on them.

## Timing
- **Reset values:**
  - grant_q=1 (master 0), HMASTER=0, HMASTLOCK=0.
  - dmst_q=0, dsel_q=default slave, default-slave FSM in DS_OKAY.
  - Hence HREADY=1, HRESP=OKAY, HRDATA=0.
- **Request latency:** HBUSREQ_M sampled at edge t gives HGRANT at t+1 and HMASTER at t+2, provided HREADY=1 at both edges.
- **Wait states:** while HREADY=0, grant_q, HMASTER, dmst_q and dsel_q all hold. A slave wait state stalls handover.
- **Lock:** while a locked master holds HLOCK_M=1, no other request wins. The grant releases on the first HREADY=1 edge after HLOCK_M drops.
- **Simultaneous requests:** resolved in one cycle; no bubble is added beyond the AHB handover.
- **Reset mid-transfer:** an in-flight data phase is abandoned. HREADY is 1 in the cycle after reset deasserts.

## Configuration
- AHB_RR_ARB_EN defined:
  - Round-robin arbitration. The search starts at (last granted index + 1) mod N_MST.
  - A last_q pointer (reset 0) updates on each grant change.
- AHB_RR_ARB_EN undefined:
  - Fixed priority; lowest index wins.
  - No last_q register exists.

## Structure
- Package ahb_bus_pkg holds:
  - HTRANS codes (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
  - HRESP codes (OKAY=0, ERROR=1, RETRY=2, SPLIT=3)
  - HSIZE codes and the default-slave state enum
- Sub-module ahb_arbiter contains grant_q, last_q, HMASTER and HMASTLOCK.
- Decoder, muxes and default slave stay in ahb_bus_nxm.

## Test plan
- **Reset to default ownership:** Reset then no requests → HGRANT_M=2'b01, HMASTER=0, HREADY=1, HRESP=0.
- **Single requester:** M1 requests, NONSEQ read 0x0001_0000 (slave 1 base 0x0001_0000, mask 0xFFFF_0000), slave HRDATA_S=0xDEADBEEF → HGRANT at t+1, HSEL_S[1]=1, HRDATA=0xDEADBEEF with HREADY=1.
- **Unmapped address:** NONSEQ write to 0xF000_0000 → one cycle HREADY=0/HRESP=ERROR, then HREADY=1/HRESP=ERROR, then OKAY.
- **Lock:** M0 holds HLOCK, 4-beat burst, while M1 requests → HGRANT stays on M0 for all beats; M1 granted on the first HREADY edge after HLOCK drops.
- **Wait state during request:** slave holds HREADY_S=0 for 3 cycles while M1 requests → HMASTER and dsel_q unchanged until HREADY returns.
- **Both masters requesting every cycle:**
  - With AHB_RR_ARB_EN: grants alternate M0, M1, M0.
  - Without it: M0 keeps the grant indefinitely.
